// File: rtl/key_expansion_seq.sv
// Sequential AES-128/192/256 key schedule: one schedule word per clock into
// local storage, then any round key is served through a registered read port.
module key_expansion_seq #(
   parameter int unsigned MAX_KEY_BITS = 256
) (
   input  logic         iClk,
   input  logic         iRst,
   input  logic         iStart,
   input  logic [1:0]   iKeyLen,
   input  logic [255:0] iKey,
   input  logic [3:0]   iRkIdx,
   output logic [127:0] oRoundKey,
   output logic [3:0]   oNumRounds,
   output logic         oBusy,
   output logic         oReady,
   output logic         oDone,
   output logic         oErr
);

   localparam int unsigned NR_MAX    = (MAX_KEY_BITS >= 256) ? 14 :
                                       (MAX_KEY_BITS >= 192) ? 12 : 10;
   localparam int unsigned NUM_WORDS = 4 * (NR_MAX + 1);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   // Rejects reserved lengths and key sizes beyond the storage built here.
   function automatic logic mode_ok(input logic [1:0] kl);
      case (kl)
         2'd0:    return 1'b1;
         2'd1:    return (MAX_KEY_BITS >= 192);
         2'd2:    return (MAX_KEY_BITS >= 256);
         default: return 1'b0;
      endcase
   endfunction

   state_t         state_q,  state_d;
   logic [255:0]   key_q,    key_d;
   logic [1:0]     klen_q,   klen_d;
   logic [5:0]     i_q,      i_d;
   logic [2:0]     j_q,      j_d;
   logic [7:0]     rcon_q,   rcon_d;
   logic [127:0]   rk_q,     rk_d;
   logic [3:0]     nr_q,     nr_d;
   logic           busy_q,   busy_d;
   logic           ready_q,  ready_d;
   logic           done_q,   done_d;
   logic           err_q,    err_d;

   logic [31:0]    w_mem [NUM_WORDS];

   logic [5:0]     nk_c;
   logic [3:0]     nr_c;
   logic [5:0]     nw_c;
   logic [7:0]     load_mask_c;
   logic           load_en_c;
   logic           exp_en_c;
   logic [31:0]    prev_w_c;
   logic [31:0]    old_w_c;
   logic [31:0]    sub_in_c;
   logic [31:0]    sub_out_c;
   logic [31:0]    temp_c;
   logic [31:0]    new_w_c;
   logic [7:0]     rcon_next_c;
   logic [5:0]     rd_base_c;

   // Mode constants for the latched key length.
   always_comb begin
      nk_c        = 6'd4;
      nr_c        = 4'd10;
      nw_c        = 6'd44;
      load_mask_c = 8'h0f;
      case (klen_q)
         2'd1: begin
            nk_c        = 6'd6;
            nr_c        = 4'd12;
            nw_c        = 6'd52;
            load_mask_c = 8'h3f;
         end
         2'd2: begin
            nk_c        = 6'd8;
            nr_c        = 4'd14;
            nw_c        = 6'd60;
            load_mask_c = 8'hff;
         end
         default: ;
      endcase
   end

   // Next schedule word: RotWord/SubWord/Rcon on j==0, extra SubWord at j==4 for AES-256.
   always_comb begin
      prev_w_c    = w_mem[6'(i_q - 6'd1)];
      old_w_c     = w_mem[6'(i_q - nk_c)];
      sub_in_c    = (j_q == 3'd0) ? {prev_w_c[23:0], prev_w_c[31:24]} : prev_w_c;
      sub_out_c   = {sbox(sub_in_c[31:24]), sbox(sub_in_c[23:16]),
                     sbox(sub_in_c[15:8]),  sbox(sub_in_c[7:0])};
      if (j_q == 3'd0) begin
         temp_c = sub_out_c ^ {rcon_q, 24'h0};
      end else if ((nk_c == 6'd8) && (j_q == 3'd4)) begin
         temp_c = sub_out_c;
      end else begin
         temp_c = prev_w_c;
      end
      new_w_c     = old_w_c ^ temp_c;
      rcon_next_c = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
   end

   // Control FSM next state, schedule counters and output next values.
   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      klen_d    = klen_q;
      i_d       = i_q;
      j_d       = j_q;
      rcon_d    = rcon_q;
      nr_d      = nr_q;
      ready_d   = ready_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      load_en_c = 1'b0;
      exp_en_c  = 1'b0;
      rk_d      = 128'h0;
      rd_base_c = {iRkIdx, 2'b00};

      case (state_q)
         S_IDLE, S_DONE: begin
            if (iStart) begin
               if (mode_ok(iKeyLen)) begin
                  key_d   = iKey;
                  klen_d  = iKeyLen;
                  ready_d = 1'b0;
                  state_d = S_LOAD;
               end else begin
                  err_d   = 1'b1;
               end
            end
         end
         S_LOAD: begin
            load_en_c = 1'b1;
            i_d       = nk_c;
            j_d       = 3'd0;
            rcon_d    = 8'h01;
            state_d   = S_EXPAND;
         end
         S_EXPAND: begin
            if (i_q == nw_c) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               ready_d = 1'b1;
               nr_d    = nr_c;
            end else begin
               exp_en_c = 1'b1;
               i_d      = i_q + 6'd1;
               j_d      = (j_q == 3'(nk_c - 6'd1)) ? 3'd0 : j_q + 3'd1;
               if (j_q == 3'd0) begin
                  rcon_d = rcon_next_c;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_LOAD) || (state_d == S_EXPAND);

      // Gate with the next ready so a restart hides old keys on its accept edge.
      if (ready_d && (iRkIdx <= nr_c)) begin
         rk_d = {w_mem[rd_base_c], w_mem[rd_base_c | 6'd1],
                 w_mem[rd_base_c | 6'd2], w_mem[rd_base_c | 6'd3]};
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= S_IDLE;
         key_q   <= 256'h0;
         klen_q  <= 2'd0;
         i_q     <= 6'd0;
         j_q     <= 3'd0;
         rcon_q  <= 8'h01;
         rk_q    <= 128'h0;
         nr_q    <= 4'd0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         klen_q  <= klen_d;
         i_q     <= i_d;
         j_q     <= j_d;
         rcon_q  <= rcon_d;
         rk_q    <= rk_d;
         nr_q    <= nr_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Schedule word storage; contents are only meaningful while ready.
   always_ff @(posedge iClk) begin
      if (load_en_c) begin
         w_mem[0] <= key_q[255:224];
         w_mem[1] <= key_q[223:192];
         w_mem[2] <= key_q[191:160];
         w_mem[3] <= key_q[159:128];
         if (load_mask_c[4]) w_mem[4] <= key_q[127:96];
         if (load_mask_c[5]) w_mem[5] <= key_q[95:64];
         if (load_mask_c[6]) w_mem[6] <= key_q[63:32];
         if (load_mask_c[7]) w_mem[7] <= key_q[31:0];
      end
      if (exp_en_c) begin
         w_mem[i_q] <= new_w_c;
      end
   end

   assign oRoundKey  = rk_q;
   assign oNumRounds = nr_q;
   assign oBusy      = busy_q;
   assign oReady     = ready_q;
   assign oDone      = done_q;
   assign oErr       = err_q;

endmodule

// File: doc/key_expansion_seq.md
Name: key_expansion_seq

Overview:
Sequential, mode-selectable AES key schedule for AES-128/192/256. It is the successor to the combinational KeyExpansion block. It accepts a cipher key on a start handshake, generates one 32-bit schedule word per clock into internal storage, then serves any round key through a registered read port. It sits between key load logic and the round datapath, replacing the 1408-bit flat round-key bus with an indexed port.

Parameters:
MAX_KEY_BITS, 256, largest supported key size (128, 192 or 256); sets word storage to 4*(Nr_max+1) words (44, 52 or 60).

Ports:
iClk  input  1  clock; all logic on the rising edge
iRst  input  1  reset, synchronous, active-high
iStart  input  1  start request; 1-cycle pulse or level, sampled only in IDLE/DONE
iKeyLen  input  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved
iKey  input  256  cipher key, left-justified; the first key byte is iKey[255:248]; unused LSBs ignored
iRkIdx  input  4  round-key index to read, 0..Nr
oRoundKey  output  128  round key iRkIdx; word w[4r] in bits [127:96]; registered
oNumRounds  output  4  Nr of the latched mode: 10/12/14; 0 after reset
oBusy  output  1  high in LOAD and EXPAND
oReady  output  1  high while a complete schedule is stored
oDone  output  1  1-cycle pulse when the schedule completes
oErr  output  1  1-cycle pulse when a start is rejected

Behaviour:
- Reset values: oRoundKey=0, oNumRounds=0, oBusy=0, oReady=0, oDone=0, oErr=0, state=IDLE. Word storage is not reset.
- Mode: Nk = 4/6/8 and Nr = 10/12/14; total words W = 4*(Nr+1) = 44/52/60.
- States are IDLE, LOAD, EXPAND and DONE.
- Start acceptance (IDLE or DONE, iStart=1):
  - A legal mode latches iKey and iKeyLen, clears oReady, and moves to LOAD.
  - iKeyLen=3, or a mode exceeding MAX_KEY_BITS (e.g. 192/256 with MAX_KEY_BITS=128), pulses oErr for 1 cycle. State, oReady and storage are unchanged.
- iStart in LOAD/EXPAND is ignored; no error is raised.
- LOAD (1 cycle):
  - Writes w[0..Nk-1] from the latched key, MSB-first.
  - Initialises word index i=Nk, mod-Nk counter j=0 and Rcon=0x01.
- EXPAND (one word per cycle, i = Nk..W-1):
  - temp = w[i-1].
  - If j==0: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}, and Rcon is then updated by xtime (0x80 -> 0x1b).
  - Else if Nk==8 and j==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp; j wraps at Nk. Division and modulo operators are not used.
  - After writing w[W-1], the FSM goes to DONE.
- DONE entry cycle: oDone=1 for exactly one cycle, oReady=1, oBusy=0, oNumRounds=Nr.
- Latency: the oDone rising edge occurs (W-Nk)+2 edges after the edge sampling iStart, i.e. 42 (128), 48 (192) or 54 (256).
- SubWord uses 4 internal combinational S-box lookups (FIPS-197 table).
- Read port:
  - oRoundKey is updated every cycle from iRkIdx with 1-cycle latency.
  - It reads 0 when oReady=0 or iRkIdx>Nr.
  - Reads are legal during a restart but return 0 until the new oReady.
- Restart from DONE behaves identically to a start from IDLE; old keys become unreadable immediately.
- iRst mid-operation: the next cycle is IDLE with all outputs at reset values; no oDone is issued.

Test Plan:
- AES-128, key 000102030405060708090a0b0c0d0e0f -> oDone 42 cycles after start; idx0=000102030405060708090a0b0c0d0e0f, idx1=d6aa74fdd2af72fadaa678f1d6ab76fe, idx10=13111d7fe3944a17f307a78b4d2b30c5; oNumRounds=10.
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> idx10=d014f9a8c9ee2589e13f0cc8b6630ca6; all 11 keys match the FIPS-197 Appendix A list.
- AES-192, key 000102..1617 -> oDone after 48 cycles; oNumRounds=12; idx12=a4970a331a78dc09c418c271e3a41d5d; idx13 reads 0.
- AES-256, key 000102..1e1f -> oDone after 54 cycles; idx14=24fc79ccbf0979e9371ac23c6d68de36.
- iKeyLen=3 from DONE -> oErr pulse, oReady stays 1, previous keys still readable; with MAX_KEY_BITS=128, iKeyLen=2 -> oErr.
- iRst asserted mid-EXPAND (cycle 20) -> next cycle all outputs 0, no oDone; a fresh start then completes correctly. iStart pulsed while busy -> ignored, latency unchanged.
